// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
// Divide-by-zero completes in one cycle with quotient=all-ones and remainder=dividend.
`timescale 1ns/1ps
module seq_restoring_divider #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvs_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and results hold until consumed.

  // The stored partial remainder is always below the divisor, so its top bit is
  // always zero and only the low WIDTH bits are kept between iterations.
  always_comb begin
    shifted = {rem_r, q_r[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_r};
    rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_nxt   = (q_r << 1) | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem_r       <= '0;
      q_r         <= '0;
      dvs_r       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvs_r <= divisor;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              rem_r <= '0;
              q_r   <= dividend;
              cnt   <= CW'(WIDTH - 1);
            end
          end
        end
        RUN: begin
          rem_r <= rem_nxt;
          q_r   <= q_nxt;
          // Results are published only on the final iteration.
          if (cnt == '0) begin
            quotient    <= q_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: WIDTH=2 and WIDTH=8 instances checked every cycle
// against an arithmetic model (a/b, a%b) with a scoreboard queue, plus literal expectations.
`timescale 1ns/1ps
module tb_seq_restoring_divider;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv0, ordy0, irdy0, ov0, z0;
  logic [1:0] a0, b0, q0, r0;
  logic       iv1, ordy1, irdy1, ov1, z1;
  logic [7:0] a1, b1, q1, r1;

  seq_restoring_divider #(.WIDTH(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(irdy0), .dividend(a0), .divisor(b0),
    .out_valid(ov0), .out_ready(ordy0), .quotient(q0), .remainder(r0), .div_by_zero(z0));

  seq_restoring_divider #(.WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(irdy1), .dividend(a1), .divisor(b1),
    .out_valid(ov1), .out_ready(ordy1), .quotient(q1), .remainder(r1), .div_by_zero(z1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(int k, string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[w%0d] at %0t: got %0h expected %0h", name, (k == 0) ? 2 : 8, $time, act, exp);
    end
  endtask

  function automatic logic get_irdy(int k); return (k == 0) ? irdy0 : irdy1; endfunction
  function automatic logic get_ov(int k);   return (k == 0) ? ov0 : ov1;     endfunction
  function automatic logic get_z(int k);    return (k == 0) ? z0 : z1;       endfunction
  function automatic logic get_iv(int k);   return (k == 0) ? iv0 : iv1;     endfunction
  function automatic logic get_ordy(int k); return (k == 0) ? ordy0 : ordy1; endfunction
  function automatic logic [7:0] get_q(int k); return (k == 0) ? {6'b0, q0} : q1; endfunction
  function automatic logic [7:0] get_r(int k); return (k == 0) ? {6'b0, r0} : r1; endfunction
  function automatic logic [7:0] get_a(int k); return (k == 0) ? {6'b0, a0} : a1; endfunction
  function automatic logic [7:0] get_b(int k); return (k == 0) ? {6'b0, b0} : b1; endfunction

  // ---------------- reference model + scoreboard ----------------
  // Expected result word: {div_by_zero, quotient[7:0], remainder[7:0]}.
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  int          m_st[2];   // 0 idle, 1 computing, 2 result presented
  int          m_cnt[2];
  logic [16:0] m_out[2];  // values the result outputs must currently show

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k]  = 0;
      m_cnt[k] = 0;
      m_out[k] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic present(int k);
    m_out[k] = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    m_st[k]  = 2;
  endtask

  task automatic model_step(int k);
    int          w;
    logic [7:0]  mask, a, b;
    logic [16:0] e;
    w    = (k == 0) ? 2 : 8;
    mask = (k == 0) ? 8'h03 : 8'hff;
    chk(k, "in_ready", get_irdy(k), m_st[k] == 0);
    chk(k, "out_valid", get_ov(k), m_st[k] == 2);
    chk(k, "quotient", get_q(k), m_out[k][15:8]);
    chk(k, "remainder", get_r(k), m_out[k][7:0]);
    chk(k, "div_by_zero", get_z(k), m_out[k][16]);
    case (m_st[k])
      0: if (get_iv(k)) begin
        a = get_a(k);
        b = get_b(k);
        if (b == 0) e = {1'b1, mask, a};
        else        e = {1'b0, 8'(a / b), 8'(a % b)};
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        if (b == 0) present(k);
        else begin
          m_st[k]  = 1;
          m_cnt[k] = w;
        end
      end
      1: begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) present(k);
      end
      default: if (get_ordy(k)) m_st[k] = 0;
    endcase
  endtask

  always @(negedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- driver tasks (called at posedge+#1) ----------------
  task automatic set_in(int k, logic v, logic [7:0] a, logic [7:0] b);
    if (k == 0) begin iv0 = v; a0 = a[1:0]; b0 = b[1:0]; end
    else        begin iv1 = v; a1 = a;      b1 = b;      end
  endtask

  task automatic set_ordy(int k, logic v);
    if (k == 0) ordy0 = v;
    else        ordy1 = v;
  endtask

  task automatic send(int k, logic [7:0] a, logic [7:0] b);
    int n = 0;
    while (!get_irdy(k) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk(k, "ready_wait", get_irdy(k), 1);
    set_in(k, 1'b1, a, b);
    @(posedge clk); #1;
    set_in(k, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  task automatic wait_done(int k, output int lat);
    lat = 1;
    while (!get_ov(k) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk(k, "done_wait", get_ov(k), 1);
  endtask

  task automatic consume(int k, int hold);
    repeat (hold) begin @(posedge clk); #1; end
    set_ordy(k, 1'b1);
    @(posedge clk); #1;
    set_ordy(k, 1'b0);
  endtask

  task automatic dir_op(int k, logic [7:0] a, logic [7:0] b, logic [7:0] eq, logic [7:0] er,
                        logic ez, int elat);
    int lat;
    send(k, a, b);
    wait_done(k, lat);
    chk(k, "latency", lat, elat);
    chk(k, "lit_q", get_q(k), eq);
    chk(k, "lit_r", get_r(k), er);
    chk(k, "lit_dbz", get_z(k), ez);
    consume(k, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [7:0] aa, bb;
    iv0 = 0; ordy0 = 0; a0 = 0; b0 = 0;
    iv1 = 0; ordy1 = 0; a1 = 0; b1 = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_in_ready", get_irdy(k), 1);
      chk(k, "rst_out_valid", get_ov(k), 0);
      chk(k, "rst_q", get_q(k), 0);
      chk(k, "rst_r", get_r(k), 0);
      chk(k, "rst_dbz", get_z(k), 0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 0;
    @(posedge clk); #1;

    // WIDTH=2 hand-computed cases
    dir_op(0, 3, 1, 3, 0, 0, 3);
    dir_op(0, 3, 2, 1, 1, 0, 3);
    dir_op(0, 2, 3, 0, 2, 0, 3);
    dir_op(0, 0, 2, 0, 0, 0, 3);
    dir_op(0, 3, 3, 1, 0, 0, 3);
    dir_op(0, 2, 0, 3, 2, 1, 1);

    // Backpressure: result held, new request ignored
    send(0, 3, 2);
    wait_done(0, lat);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1'b1, 8'd1, 8'd1);
      @(posedge clk); #1;
      chk(0, "hold_valid", ov0, 1);
      chk(0, "hold_ready", irdy0, 0);
      chk(0, "hold_q", q0, 1);
      chk(0, "hold_r", r0, 1);
    end
    set_in(0, 1'b0, 8'd0, 8'd0);
    consume(0, 0);
    chk(0, "idle_valid", ov0, 0);
    chk(0, "idle_ready", irdy0, 1);
    chk(0, "idle_hold_q", q0, 1);

    // Async reset during the second compute cycle
    dir_op(0, 2, 0, 3, 2, 1, 1);
    send(0, 3, 1);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk(0, "arst_in_ready", irdy0, 1);
    chk(0, "arst_out_valid", ov0, 0);
    chk(0, "arst_q", q0, 0);
    chk(0, "arst_r", r0, 0);
    chk(0, "arst_dbz", z0, 0);
    #1 rst = 0;
    @(posedge clk); #1;
    dir_op(0, 1, 1, 1, 0, 0, 3);

    // Exhaustive WIDTH=2
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        send(0, 8'(a), 8'(b));
        wait_done(0, lat);
        chk(0, "sweep_latency", lat, (b == 0) ? 1 : 3);
        consume(0, $urandom_range(0, 2));
      end

    // WIDTH=8 boundaries
    dir_op(1, 255, 255, 1, 0, 0, 9);
    dir_op(1, 200, 1, 200, 0, 0, 9);
    dir_op(1, 5, 200, 0, 5, 0, 9);
    dir_op(1, 0, 7, 0, 0, 0, 9);
    dir_op(1, 77, 0, 255, 77, 1, 1);

    // WIDTH=8 random
    for (int i = 0; i < 2500; i++) begin
      aa = 8'($urandom_range(0, 255));
      bb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      send(1, aa, bb);
      wait_done(1, lat);
      chk(1, "rand_latency", lat, (bb == 0) ? 1 : 9);
      consume(1, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    // Round trip: (A*B)/B must give back A
    for (int i = 0; i < 200; i++) begin
      bb = 8'($urandom_range(1, 15));
      aa = 8'($urandom_range(0, 255 / int'(bb)));
      send(1, 8'(aa * bb), bb);
      wait_done(1, lat);
      chk(1, "roundtrip_q", q1, aa);
      chk(1, "roundtrip_r", r1, 0);
      consume(1, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk(0, "queue_empty", exp_q0.size(), 0);
    chk(1, "queue_empty", exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
